mem_port_arbiter: RTL and testbench



---
 rtl/lc3b_types.sv | 15 +
 rtl/mem_port_arbiter_chk.sv | 28 ++
 rtl/mem_port_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: data word, byte mask and the memory port arbiter state/constants.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_A = 2'd1,
        ARB_GRANT_B = 2'd2
    } lc3b_arb_state;

    localparam int unsigned ARB_STREAK_W = 4;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Simulation-only protocol checks for mem_port_arbiter: read+write overlap and resp exclusivity.
module mem_port_arbiter_chk
    import lc3b_types::*;
(
    input logic          clk,
    input logic          rst_n,
    input lc3b_arb_state state,
    input logic          read_a,
    input logic          write_a,
    input logic          read_b,
    input logic          write_b,
    input logic          resp_a,
    input logic          resp_b
);

    // Flag a granted port driving read and write together, and overlapping completions.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(state == ARB_GRANT_A && read_a && write_a))
                else $warning("port A read and write both high; write performed");
            assert (!(state == ARB_GRANT_B && read_b && write_b))
                else $warning("port B read and write both high; write performed");
            assert (!(resp_a && resp_b))
                else $error("resp_a and resp_b high in the same cycle");
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port to one-port memory arbiter: fixed B priority with an A starvation guard,
// or round-robin when ARB_ROUND_ROBIN_EN is defined.
module mem_port_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned MAX_B_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          read_a,
    input  logic          write_a,
    input  lc3b_mem_wmask wmask_a,
    input  lc3b_word      address_a,
    input  lc3b_word      wdata_a,
    output logic          resp_a,
    output lc3b_word      rdata_a,
    input  logic          read_b,
    input  logic          write_b,
    input  lc3b_mem_wmask wmask_b,
    input  lc3b_word      address_b,
    input  lc3b_word      wdata_b,
    output logic          resp_b,
    output lc3b_word      rdata_b,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_mem_wmask pmem_wmask,
    output lc3b_word      pmem_address,
    output lc3b_word      pmem_wdata,
    input  logic          pmem_resp,
    input  lc3b_word      pmem_rdata
);

    lc3b_arb_state state_r, next_state_s;
    logic          req_a_s, req_b_s;
    logic          pick_a_s, pick_b_s;

    assign req_a_s = read_a | write_a;
    assign req_b_s = read_b | write_b;
    assign rdata_a = pmem_rdata;
    assign rdata_b = pmem_rdata;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_b_r, next_last_b_s;

    // Grant choice in IDLE: on contention the port not granted last wins.
    always_comb begin
        pick_a_s = 1'b0;
        pick_b_s = 1'b0;
        if (req_a_s && req_b_s) begin
            pick_b_s = ~last_b_r;
            pick_a_s = last_b_r;
        end else begin
            pick_a_s = req_a_s;
            pick_b_s = req_b_s;
        end
    end

    // Remember which port took the most recent grant.
    always_comb begin
        next_last_b_s = last_b_r;
        if (state_r == ARB_IDLE && pick_b_s) begin
            next_last_b_s = 1'b1;
        end else if (state_r == ARB_IDLE && pick_a_s) begin
            next_last_b_s = 1'b0;
        end else begin
            next_last_b_s = last_b_r;
        end
    end

    // Last-grant register, reset to A so the first contention goes to B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_r <= 1'b0;
        end else begin
            last_b_r <= next_last_b_s;
        end
    end
`else
    localparam logic [ARB_STREAK_W-1:0] MAX_STREAK = ARB_STREAK_W'(MAX_B_STREAK);

    logic [ARB_STREAK_W-1:0] streak_r, next_streak_s;
    logic                    a_pend_r, next_a_pend_s;

    // Grant choice in IDLE: B first unless A has waited through MAX_B_STREAK B grants.
    always_comb begin
        pick_b_s = req_b_s && (!req_a_s || (streak_r < MAX_STREAK));
        pick_a_s = req_a_s && !pick_b_s;
    end

    // a_pend latches whether A was waiting when B was granted; streak updates on completion.
    always_comb begin
        next_streak_s = streak_r;
        next_a_pend_s = a_pend_r;
        if (state_r == ARB_IDLE && pick_b_s) begin
            next_a_pend_s = req_a_s;
        end else if (state_r == ARB_GRANT_A && pmem_resp) begin
            next_streak_s = {ARB_STREAK_W{1'b0}};
        end else if (state_r == ARB_GRANT_B && pmem_resp) begin
            if (!a_pend_r) begin
                next_streak_s = {ARB_STREAK_W{1'b0}};
            end else if (streak_r >= MAX_STREAK) begin
                next_streak_s = MAX_STREAK;
            end else begin
                next_streak_s = streak_r + 4'd1;
            end
        end else begin
            next_streak_s = streak_r;
        end
    end

    // Starvation-guard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_r <= {ARB_STREAK_W{1'b0}};
            a_pend_r <= 1'b0;
        end else begin
            streak_r <= next_streak_s;
            a_pend_r <= next_a_pend_s;
        end
    end
`endif

    // FSM next state: grants hold until pmem_resp, then always pass through IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_b_s) begin
                    next_state_s = ARB_GRANT_B;
                end else if (pick_a_s) begin
                    next_state_s = ARB_GRANT_A;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_GRANT_A, ARB_GRANT_B: begin
                if (pmem_resp) begin
                    next_state_s = ARB_IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = ARB_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Output mux: mirror the granted port; a write wins over a simultaneous read.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wmask   = 2'b00;
        pmem_address = 16'h0000;
        pmem_wdata   = 16'h0000;
        resp_a       = 1'b0;
        resp_b       = 1'b0;
        case (state_r)
            ARB_GRANT_A: begin
                pmem_read    = read_a & ~write_a;
                pmem_write   = write_a;
                pmem_wmask   = wmask_a;
                pmem_address = address_a;
                pmem_wdata   = wdata_a;
                resp_a       = pmem_resp;
            end
            ARB_GRANT_B: begin
                pmem_read    = read_b & ~write_b;
                pmem_write   = write_b;
                pmem_wmask   = wmask_b;
                pmem_address = address_b;
                pmem_wdata   = wdata_b;
                resp_b       = pmem_resp;
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

`ifndef SYNTHESIS
    mem_port_arbiter_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .state   (state_r),
        .read_a  (read_a),
        .write_a (write_a),
        .read_b  (read_b),
        .write_b (write_b),
        .resp_a  (resp_a),
        .resp_b  (resp_b)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, grant-order and reset
// sequences, and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_a, write_a, read_b, write_b;
    logic [1:0]  wmask_a, wmask_b;
    logic [15:0] address_a, wdata_a, address_b, wdata_b;
    logic        resp_a, resp_b;
    logic [15:0] rdata_a, rdata_b;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address, pmem_wdata, pmem_rdata;

    int total = 0;
    int bad   = 0;

    // reference model: who owns the memory port, B-streak length, round-robin memory
    int m_owner;   // 0 none, 1 A, 2 B
    int m_streak;
    bit m_a_waited;
    bit m_last_b;

    mem_port_arbiter #(.MAX_B_STREAK(MAXS)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
        .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ra, wa, rb, wb, presp;
        logic e_read, e_write;
        logic [1:0] e_wmask;
        logic [15:0] e_addr;
        logic e_resp_a, e_resp_b;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
        wmask_a = 2'b11; wmask_b = 2'b01;
        address_a = 16'h1000; address_b = 16'h2002;
        wdata_a = 16'h0000; wdata_b = 16'h55AA;
        pmem_resp = 1'b0; pmem_rdata = 16'hBEEF;
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        clear_inputs();
        pmem_resp = 1'b1;
        #2;
        if (check) begin
            chk("reset_pmem_read", 32'(pmem_read), 32'd0);
            chk("reset_pmem_write", 32'(pmem_write), 32'd0);
            chk("reset_pmem_addr", 32'(pmem_address), 32'd0);
            chk("reset_resp", 32'({resp_a, resp_b}), 32'd0);
        end
        tick();
        pmem_resp = 1'b0;
        rst_n = 1'b1;
        m_owner = 0; m_streak = 0; m_a_waited = 1'b0; m_last_b = 1'b0;
    endtask

    // compare current DUT outputs with what the model says the owner should see
    task automatic model_check();
        logic e_rd, e_wr, e_ra, e_rb;
        logic [1:0] e_mk;
        logic [15:0] e_ad, e_wd;
        e_rd = 1'b0; e_wr = 1'b0; e_ra = 1'b0; e_rb = 1'b0;
        e_mk = 2'b00; e_ad = 16'h0000; e_wd = 16'h0000;
        if (m_owner == 1) begin
            e_wr = write_a; e_rd = read_a && !write_a; e_mk = wmask_a;
            e_ad = address_a; e_wd = wdata_a; e_ra = pmem_resp;
        end else if (m_owner == 2) begin
            e_wr = write_b; e_rd = read_b && !write_b; e_mk = wmask_b;
            e_ad = address_b; e_wd = wdata_b; e_rb = pmem_resp;
        end
        chk("rnd_strobes", 32'({pmem_read, pmem_write}), 32'({e_rd, e_wr}));
        chk("rnd_wmask", 32'(pmem_wmask), 32'(e_mk));
        chk("rnd_addr", 32'(pmem_address), 32'(e_ad));
        chk("rnd_wdata", 32'(pmem_wdata), 32'(e_wd));
        chk("rnd_resp", 32'({resp_a, resp_b}), 32'({e_ra, e_rb}));
        chk("rnd_rdata", 32'({rdata_a, rdata_b}), {pmem_rdata, pmem_rdata});
    endtask

    // advance the model by one clock using the arbitration rules
    task automatic model_step();
        bit qa, qb;
        qa = read_a || write_a;
        qb = read_b || write_b;
        if (m_owner == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (qa && qb) m_owner = m_last_b ? 1 : 2;
            else if (qb) m_owner = 2;
            else if (qa) m_owner = 1;
            if (m_owner != 0) m_last_b = (m_owner == 2);
`else
            if (qb && (!qa || m_streak < MAXS)) begin
                m_owner = 2;
                m_a_waited = qa;
            end else if (qa) begin
                m_owner = 1;
            end
`endif
        end else if (pmem_resp) begin
            if (m_owner == 1) m_streak = 0;
            else m_streak = m_a_waited ? ((m_streak + 1 > MAXS) ? MAXS : m_streak + 1) : 0;
            m_owner = 0;
        end
    endtask

    initial begin
        string got, want;
        int bleft, cyc;
        bit a_done;

        //          ra wa rb wb rsp  rd wr mask  addr      rA rB
        vecs[0]  = '{1, 0, 0, 0, 0,   0, 0, 2'b00, 16'h0000, 0, 0};
        vecs[1]  = '{1, 0, 0, 0, 0,   1, 0, 2'b11, 16'h1000, 0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0,   1, 0, 2'b11, 16'h1000, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 1,   1, 0, 2'b11, 16'h1000, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, 0,   0, 0, 2'b00, 16'h0000, 0, 0};
        vecs[5]  = '{1, 0, 0, 1, 0,   0, 0, 2'b00, 16'h0000, 0, 0};
        vecs[6]  = '{1, 0, 0, 1, 0,   0, 1, 2'b01, 16'h2002, 0, 0};
        vecs[7]  = '{1, 0, 0, 1, 1,   0, 1, 2'b01, 16'h2002, 0, 1};
        vecs[8]  = '{1, 0, 0, 0, 0,   0, 0, 2'b00, 16'h0000, 0, 0};
        vecs[9]  = '{1, 0, 0, 0, 1,   1, 0, 2'b11, 16'h1000, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 1,   0, 0, 2'b00, 16'h0000, 0, 0};
        vecs[11] = '{1, 1, 0, 0, 0,   0, 0, 2'b00, 16'h0000, 0, 0};
        vecs[12] = '{1, 1, 0, 0, 0,   0, 1, 2'b11, 16'h1000, 0, 0};
        vecs[13] = '{1, 1, 0, 0, 1,   0, 1, 2'b11, 16'h1000, 1, 0};
        vecs[14] = '{0, 0, 0, 0, 0,   0, 0, 2'b00, 16'h0000, 0, 0};

        do_reset(1'b1);

        // directed vectors: A read, B write vs A, stray resp, read+write overlap
        for (int i = 0; i < 15; i++) begin
            read_a = vecs[i].ra; write_a = vecs[i].wa;
            read_b = vecs[i].rb; write_b = vecs[i].wb;
            pmem_resp = vecs[i].presp;
            #2;
            chk($sformatf("vec%0d_strobes", i), 32'({pmem_read, pmem_write}),
                32'({vecs[i].e_read, vecs[i].e_write}));
            chk($sformatf("vec%0d_wmask", i), 32'(pmem_wmask), 32'(vecs[i].e_wmask));
            chk($sformatf("vec%0d_addr", i), 32'(pmem_address), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d_resp", i), 32'({resp_a, resp_b}),
                32'({vecs[i].e_resp_a, vecs[i].e_resp_b}));
            chk($sformatf("vec%0d_rdata", i), 32'(rdata_a), 32'h0000BEEF);
            tick();
        end

        // A held while B issues 6 requests; record grant order
        do_reset(1'b0);
        got = ""; bleft = 6; a_done = 1'b0; cyc = 0;
        while (got.len() < 7 && cyc < 100) begin
            read_a = !a_done; read_b = (bleft > 0); pmem_resp = 1'b0;
            #2;
            if (pmem_read) begin
                pmem_resp = 1'b1;
                if (pmem_address == 16'h1000) begin
                    got = {got, "A"}; a_done = 1'b1;
                end else begin
                    got = {got, "B"}; bleft--;
                end
            end
            tick();
            cyc++;
        end
`ifdef ARB_ROUND_ROBIN_EN
        want = "BABBBBB";
`else
        want = "BBBBABB";
`endif
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL grant_order: got %s expected %s (cycles %0d)", got, want, cyc);
        end

        // reset while B is granted, then a late pmem_resp
        do_reset(1'b0);
        write_b = 1'b1;
        tick();
        #2;
        chk("grantb_write", 32'(pmem_write), 32'd1);
        rst_n = 1'b0;
        pmem_resp = 1'b1;
        #1;
        chk("midrst_strobes", 32'({pmem_read, pmem_write}), 32'd0);
        chk("midrst_addr", 32'(pmem_address), 32'd0);
        chk("midrst_resp", 32'({resp_a, resp_b}), 32'd0);
        tick();
        rst_n = 1'b1;
        write_b = 1'b0;
        #2;
        chk("late_resp_b", 32'({resp_a, resp_b}), 32'd0);
        chk("late_resp_write", 32'(pmem_write), 32'd0);
        tick();

        // randomized traffic against the reference model
        do_reset(1'b0);
        for (int c = 0; c < 3000; c++) begin
            int sa, sb;
            sa = $urandom_range(0, 2);
            sb = $urandom_range(0, 2);
            read_a = (sa == 1); write_a = (sa == 2);
            read_b = (sb == 1); write_b = (sb == 2);
            wmask_a = 2'($urandom); wmask_b = 2'($urandom);
            address_a = 16'($urandom); address_b = 16'($urandom);
            wdata_a = 16'($urandom); wdata_b = 16'($urandom);
            pmem_rdata = 16'($urandom);
            pmem_resp = ($urandom_range(0, 2) == 0);
            #2;
            model_check();
            model_step();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
